// File: rtl/alu_reservation_station.sv
// Buffers dispatched ALU instructions until both operands are available, snooping
// the ALU and load-unit result buses, and issues the lowest-index ready entry each cycle.
module alu_reservation_station #(
    parameter int ENTRIES = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        dispatch_valid,
    input  logic [2:0]  dispatch_ins_id,
    input  logic [6:0]  dispatch_opcode,
    input  logic [2:0]  dispatch_funct3,
    input  logic [6:0]  dispatch_funct7,
    input  logic [31:0] dispatch_imm,
    input  logic [5:0]  dispatch_shamt,
    input  logic [31:0] dispatch_PC,
    input  logic        dispatch_is_compressed,
    input  logic        dispatch_rs1_rdy,
    input  logic [31:0] dispatch_rs1_val,
    input  logic [2:0]  dispatch_rs1_tag,
    input  logic        dispatch_rs2_rdy,
    input  logic [31:0] dispatch_rs2_val,
    input  logic [2:0]  dispatch_rs2_tag,
    input  logic        alu_rdy,
    input  logic [2:0]  res_ins_id,
    input  logic [31:0] alu_res,
    input  logic        mem_rdy,
    input  logic [2:0]  mem_ins_id,
    input  logic [31:0] mem_res,
    output logic        have_ins,
    output logic [2:0]  ins_id,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    output logic [31:0] imm_val,
    output logic [5:0]  shamt_val,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] request_PC,
    output logic        is_compressed_ins,
    output logic        rs_full
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef struct packed {
        logic        rdy;
        logic [31:0] val;
        logic [2:0]  tag;
    } opnd_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  ins_id;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [5:0]  shamt;
        logic [31:0] pc;
        logic        is_c;
        opnd_t       rs1;
        opnd_t       rs2;
    } entry_t;

    entry_t              ent_q [ENTRIES];
    entry_t              ent_d [ENTRIES];
    entry_t              disp_ent;
    entry_t              iss_ent;
    logic [ENTRIES-1:0]  valid_vec;
    logic                iss_found;
    logic [IW-1:0]       iss_sel;
    logic [IW-1:0]       free_sel;

    // Load-unit result takes priority when both buses carry the same tag.
    function automatic opnd_t snoop(input opnd_t o);
        opnd_t r;
        r = o;
        if (!o.rdy) begin
            if (mem_rdy && (o.tag == mem_ins_id)) begin
                r.rdy = 1'b1;
                r.val = mem_res;
            end else if (alu_rdy && (o.tag == res_ins_id)) begin
                r.rdy = 1'b1;
                r.val = alu_res;
            end
        end
        return r;
    endfunction

    // Downward scan so the lowest index wins for both issue and free-slot choice.
    always_comb begin
        iss_found = 1'b0;
        iss_sel   = '0;
        free_sel  = '0;
        valid_vec = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            valid_vec[i] = ent_q[i].valid;
            if (ent_q[i].valid && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy) begin
                iss_found = 1'b1;
                iss_sel   = IW'(i);
            end
            if (!ent_q[i].valid) begin
                free_sel = IW'(i);
            end
        end
    end

    assign rs_full = &valid_vec;
    assign iss_ent = ent_q[iss_sel];

    always_comb begin
        disp_ent        = '0;
        disp_ent.valid  = 1'b1;
        disp_ent.ins_id = dispatch_ins_id;
        disp_ent.opcode = dispatch_opcode;
        disp_ent.funct3 = dispatch_funct3;
        disp_ent.funct7 = dispatch_funct7;
        disp_ent.imm    = dispatch_imm;
        disp_ent.shamt  = dispatch_shamt;
        disp_ent.pc     = dispatch_PC;
        disp_ent.is_c   = dispatch_is_compressed;
        disp_ent.rs1    = snoop('{dispatch_rs1_rdy, dispatch_rs1_val, dispatch_rs1_tag});
        disp_ent.rs2    = snoop('{dispatch_rs2_rdy, dispatch_rs2_val, dispatch_rs2_tag});
    end

    // Free slot is chosen from start-of-cycle valid bits, so an entry issued
    // this cycle cannot be refilled until the next one.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].rs1 = snoop(ent_q[i].rs1);
                ent_d[i].rs2 = snoop(ent_q[i].rs2);
            end
        end
        if (iss_found) begin
            ent_d[iss_sel].valid = 1'b0;
        end
        if (dispatch_valid && !rs_full) begin
            ent_d[free_sel] = disp_ent;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            have_ins          <= 1'b0;
            ins_id            <= '0;
            rs1_val           <= '0;
            rs2_val           <= '0;
            imm_val           <= '0;
            shamt_val         <= '0;
            opcode            <= '0;
            funct3            <= '0;
            funct7            <= '0;
            request_PC        <= '0;
            is_compressed_ins <= 1'b0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    ent_q[i].valid <= 1'b0;
                end
                have_ins <= 1'b0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    ent_q[i] <= ent_d[i];
                end
                have_ins <= iss_found;
                if (iss_found) begin
                    ins_id            <= iss_ent.ins_id;
                    rs1_val           <= iss_ent.rs1.val;
                    rs2_val           <= iss_ent.rs2.val;
                    imm_val           <= iss_ent.imm;
                    shamt_val         <= iss_ent.shamt;
                    opcode            <= iss_ent.opcode;
                    funct3            <= iss_ent.funct3;
                    funct7            <= iss_ent.funct7;
                    request_PC        <= iss_ent.pc;
                    is_compressed_ins <= iss_ent.is_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed expected issue bundles.
module tb_alu_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_pipline, dispatch_valid;
    logic [2:0]  dispatch_ins_id, dispatch_funct3, dispatch_rs1_tag, dispatch_rs2_tag;
    logic [6:0]  dispatch_opcode, dispatch_funct7;
    logic [31:0] dispatch_imm, dispatch_PC, dispatch_rs1_val, dispatch_rs2_val;
    logic [5:0]  dispatch_shamt;
    logic        dispatch_is_compressed, dispatch_rs1_rdy, dispatch_rs2_rdy;
    logic        alu_rdy, mem_rdy;
    logic [2:0]  res_ins_id, mem_ins_id;
    logic [31:0] alu_res, mem_res;
    logic        have_ins, is_compressed_ins, rs_full;
    logic [2:0]  ins_id, funct3;
    logic [31:0] rs1_val, rs2_val, imm_val, request_PC;
    logic [5:0]  shamt_val;
    logic [6:0]  opcode, funct7;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_in = ~clk_in;

    alu_reservation_station #(.ENTRIES(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
        .dispatch_valid(dispatch_valid), .dispatch_ins_id(dispatch_ins_id),
        .dispatch_opcode(dispatch_opcode), .dispatch_funct3(dispatch_funct3),
        .dispatch_funct7(dispatch_funct7), .dispatch_imm(dispatch_imm),
        .dispatch_shamt(dispatch_shamt), .dispatch_PC(dispatch_PC),
        .dispatch_is_compressed(dispatch_is_compressed),
        .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs1_val(dispatch_rs1_val),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_rdy(dispatch_rs2_rdy),
        .dispatch_rs2_val(dispatch_rs2_val), .dispatch_rs2_tag(dispatch_rs2_tag),
        .alu_rdy(alu_rdy), .res_ins_id(res_ins_id), .alu_res(alu_res),
        .mem_rdy(mem_rdy), .mem_ins_id(mem_ins_id), .mem_res(mem_res),
        .have_ins(have_ins), .ins_id(ins_id), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm_val(imm_val), .shamt_val(shamt_val), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .request_PC(request_PC), .is_compressed_ins(is_compressed_ins),
        .rs_full(rs_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        flush_pipline  = 1'b0;
        alu_rdy        = 1'b0;
        mem_rdy        = 1'b0;
    endtask

    task automatic disp(input logic [2:0] id,
                        input logic r1rdy, input logic [31:0] r1v, input logic [2:0] r1t,
                        input logic r2rdy, input logic [31:0] r2v, input logic [2:0] r2t,
                        input logic [31:0] imm, input logic [31:0] pc);
        dispatch_valid         = 1'b1;
        dispatch_ins_id        = id;
        dispatch_opcode        = 7'h13;
        dispatch_funct3        = id;
        dispatch_funct7        = 7'h20;
        dispatch_shamt         = 6'd3;
        dispatch_is_compressed = 1'b1;
        dispatch_imm           = imm;
        dispatch_PC            = pc;
        dispatch_rs1_rdy = r1rdy; dispatch_rs1_val = r1v; dispatch_rs1_tag = r1t;
        dispatch_rs2_rdy = r2rdy; dispatch_rs2_val = r2v; dispatch_rs2_tag = r2t;
    endtask

    task automatic bcast(input logic av, input logic [2:0] at, input logic [31:0] ar,
                         input logic mv, input logic [2:0] mt, input logic [31:0] mr);
        alu_rdy = av; res_ins_id = at; alu_res = ar;
        mem_rdy = mv; mem_ins_id = mt; mem_res = mr;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        idle();
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dispatch_valid = 1'b0;
        bcast(0, 0, 0, 0, 0, 0);
        #2 rst_in = 1'b0;
        #1;
        check("rst_have_ins", 32'(have_ins), 0);
        check("rst_ins_id", 32'(ins_id), 0);
        check("rst_rs_full", 32'(rs_full), 0);
        check("rst_shamt", 32'(shamt_val), 0);
        @(negedge clk_in) rst_in = 1'b1;

        // Both operands ready: issue one edge after the dispatch edge
        disp(2, 1, 5, 0, 1, 0, 0, 7, 32'h100);
        tick(); idle();
        check("addi_not_yet", 32'(have_ins), 0);
        tick();
        check("addi_have", 32'(have_ins), 1);
        check("addi_id", 32'(ins_id), 2);
        check("addi_rs1", rs1_val, 5);
        check("addi_imm", imm_val, 7);
        check("addi_pc", request_PC, 32'h100);
        check("addi_opc", 32'(opcode), 32'h13);
        check("addi_f3", 32'(funct3), 2);
        check("addi_f7", 32'(funct7), 32'h20);
        check("addi_shamt", 32'(shamt_val), 3);
        check("addi_c", 32'(is_compressed_ins), 1);
        tick();
        check("addi_one_cycle", 32'(have_ins), 0);
        check("addi_id_hold", 32'(ins_id), 2);

        // Wait on ALU tag 5, captured by snoop
        disp(3, 0, 0, 5, 1, 9, 0, 0, 32'h104);
        tick(); idle(); tick();
        bcast(1, 5, 32'h1234, 0, 0, 0);
        tick(); idle();
        check("snoop_wait", 32'(have_ins), 0);
        tick();
        check("snoop_have", 32'(have_ins), 1);
        check("snoop_id", 32'(ins_id), 3);
        check("snoop_rs1", rs1_val, 32'h1234);
        check("snoop_rs2", rs2_val, 9);
        tick();

        // Dispatch bypass from load unit
        disp(4, 0, 0, 6, 1, 1, 0, 0, 32'h108);
        bcast(0, 0, 0, 1, 6, 32'hDEADBEEF);
        tick(); idle(); tick();
        check("byp_have", 32'(have_ins), 1);
        check("byp_id", 32'(ins_id), 4);
        check("byp_rs1", rs1_val, 32'hDEADBEEF);
        tick();

        // Fill all entries, drop extra dispatch, release entries 1 and 3 together
        disp(0, 0, 0, 7, 1, 0, 0, 0, 0); tick();
        disp(1, 0, 0, 2, 1, 0, 0, 0, 0); tick();
        disp(5, 0, 0, 7, 1, 0, 0, 0, 0); tick();
        disp(6, 1, 32'h10, 0, 0, 0, 3, 0, 0); tick();
        check("full_set", 32'(rs_full), 1);
        disp(7, 1, 32'h70, 0, 1, 0, 0, 0, 0); tick(); idle();
        check("full_hold", 32'(rs_full), 1);
        tick();
        check("full_drop", 32'(have_ins), 0);
        bcast(1, 2, 32'hAAAA, 1, 3, 32'hBBBB);
        tick(); idle();
        check("rel_wait", 32'(have_ins), 0);
        tick();
        check("rel1_have", 32'(have_ins), 1);
        check("rel1_id", 32'(ins_id), 1);
        check("rel1_rs1", rs1_val, 32'hAAAA);
        check("rel1_full", 32'(rs_full), 0);
        tick();
        check("rel3_have", 32'(have_ins), 1);
        check("rel3_id", 32'(ins_id), 6);
        check("rel3_rs1", rs1_val, 32'h10);
        check("rel3_rs2", rs2_val, 32'hBBBB);
        tick();
        check("rel_done", 32'(have_ins), 0);

        // Flush with three buffered (one ready) plus a concurrent dispatch
        disp(3, 1, 32'h33, 0, 1, 0, 0, 0, 0); tick();
        check("fl_not_full", 32'(rs_full), 0);
        disp(4, 1, 32'h44, 0, 1, 0, 0, 0, 0);
        flush_pipline = 1'b1;
        tick(); idle();
        check("fl_have", 32'(have_ins), 0);
        check("fl_full", 32'(rs_full), 0);
        bcast(1, 7, 32'h99, 0, 0, 0);
        tick(); idle();
        check("fl_after1", 32'(have_ins), 0);
        tick();
        check("fl_after2", 32'(have_ins), 0);
        tick();
        check("fl_after3", 32'(have_ins), 0);

        // Both buses match the same operand: load result wins
        disp(2, 0, 0, 4, 1, 0, 0, 0, 0); tick(); idle();
        bcast(1, 4, 32'h1111, 1, 4, 32'h2222);
        tick(); idle(); tick();
        check("prio_have", 32'(have_ins), 1);
        check("prio_rs1", rs1_val, 32'h2222);

        // Stall: ready entry held while rdy_in is low, dispatch ignored
        disp(1, 1, 32'h77, 0, 1, 0, 0, 0, 32'h200); tick(); idle();
        rdy_in = 1'b0;
        disp(5, 1, 32'h5555, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_have", 32'(have_ins), 0);
        end
        check("stall_id", 32'(ins_id), 2);
        check("stall_rs1", rs1_val, 32'h2222);
        rdy_in = 1'b1; idle();
        tick();
        check("resume_have", 32'(have_ins), 1);
        check("resume_id", 32'(ins_id), 1);
        check("resume_rs1", rs1_val, 32'h77);
        check("resume_pc", request_PC, 32'h200);
        rdy_in = 1'b0;
        tick();
        check("stall_have_hold", 32'(have_ins), 1);
        rdy_in = 1'b1;
        tick();
        check("stall_drop", 32'(have_ins), 0);

        // Asynchronous reset mid-run clears outputs and buffered entries
        disp(3, 1, 32'h55, 0, 1, 0, 0, 32'h9, 32'h300); tick();
        disp(6, 0, 0, 1, 1, 0, 0, 0, 0); tick(); idle();
        check("pre_rst_have", 32'(have_ins), 1);
        check("pre_rst_rs1", rs1_val, 32'h55);
        #2 rst_in = 1'b0;
        #1;
        check("mrst_have", 32'(have_ins), 0);
        check("mrst_id", 32'(ins_id), 0);
        check("mrst_rs1", rs1_val, 0);
        check("mrst_imm", imm_val, 0);
        check("mrst_pc", request_PC, 0);
        check("mrst_opc", 32'(opcode), 0);
        #2 rst_in = 1'b1;
        bcast(1, 1, 32'h42, 0, 0, 0);
        tick(); idle(); tick();
        check("mrst_discard", 32'(have_ins), 0);
        disp(5, 1, 32'h66, 0, 1, 0, 0, 0, 0); tick(); idle(); tick();
        check("post_rst_have", 32'(have_ins), 1);
        check("post_rst_id", 32'(ins_id), 5);
        check("post_rst_rs1", rs1_val, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
